// File: rtl/serializer_pkg.sv
// Shared types for the parallel-to-serial converter.
// Holds the shifter state encoding, the buffered word record and the
// data_mod validity rule used on the input handshake.
package serializer_pkg;

    // Word width the buffered record is built for; serializer_fifo.WIDTH must match.
    localparam int SER_WIDTH = 16;
    localparam int SER_MOD_W = $clog2(SER_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        PARITY
    } ser_state_t;

    typedef struct packed {
        logic [SER_WIDTH-1:0] data;
        logic [SER_MOD_W-1:0] mod;
        logic                 lsb;
    } ser_word_t;

    // A word may carry 1..SER_WIDTH bits; anything else is discarded at the input.
    function automatic logic mod_valid(input logic [SER_MOD_W-1:0] mod);
        return (mod != '0) && (mod <= SER_MOD_W'(SER_WIDTH));
    endfunction

endpackage

// File: rtl/serializer_fifo_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, head entry visible on pop_dat_o while !empty_o.
// Latency: a pushed entry is visible on pop_dat_o one cycle after the push edge; no bypass.
// Backpressure: full_o/empty_o are registered; push when full and pop when empty are ignored.
// Ports: clk_i, rst_n_i | push_i, push_dat_i, full_o | pop_i, pop_dat_o, empty_o
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic push_i,
    input  T     push_dat_i,
    output logic full_o,
    input  logic pop_i,
    output T     pop_dat_o,
    output logic empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d   = (cnt_d == (AW+1)'(DEPTH));
        empty_d  = (cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: empty_q gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/serializer_fifo.sv
// serializer_fifo: buffers words in a FIFO and shifts 1..WIDTH bits of each onto a 1-bit line,
// MSB- or LSB-first per word, back-to-back with no idle cycle between buffered words.
// Latency: word accepted at edge N into an empty idle block gives its first bit after edge N+2.
// Backpressure: data_rdy_o = !fifo_full (registered); invalid-mod words are consumed and pulse drop_o.
// Ports: clk_i, rst_n_i | data_i, data_mod_i, data_lsb_i, data_val_i, data_rdy_o |
//        ser_data_o, ser_data_val_o, ser_last_o | drop_o, busy_o
// Build option: SERIALIZER_PARITY_EN appends an even-parity bit per word, flagged by ser_last_o.
module serializer_fifo
    import serializer_pkg::*;
#(
    parameter int WIDTH      = SER_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic [$clog2(WIDTH):0] data_mod_i,
    input  logic                   data_lsb_i,
    input  logic                   data_val_i,
    output logic                   data_rdy_o,
    output logic                   ser_data_o,
    output logic                   ser_data_val_o,
    output logic                   ser_last_o,
    output logic                   drop_o,
    output logic                   busy_o
);

`ifdef SERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    ser_state_t           state_q, state_d;
    ser_word_t            word_q, word_d;
    logic [WIDTH-1:0]     sr_q, sr_d;
    logic [SER_MOD_W-1:0] cnt_q, cnt_d;
    logic                 lsb_q, lsb_d;
    logic                 par_q, par_d;
    logic                 ser_dat_q, ser_dat_d;
    logic                 ser_vld_q, ser_vld_d;
    logic                 ser_last_q, ser_last_d;
    logic                 drop_q, drop_d;
    logic                 init_q;

    ser_word_t fifo_in, fifo_head, start_word;
    logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic      in_xfer, start, next_bit;

    assign in_xfer = data_val_i & data_rdy_o;

    always_comb begin
        fifo_in.data = data_i;
        fifo_in.mod  = data_mod_i;
        fifo_in.lsb  = data_lsb_i;
    end

    // Invalid words complete the handshake but never reach the FIFO.
    assign fifo_push = in_xfer & mod_valid(data_mod_i);
    assign drop_d    = in_xfer & ~mod_valid(data_mod_i);

    sync_fifo #(
        .T     (ser_word_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (fifo_push),
        .push_dat_i (fifo_in),
        .full_o     (fifo_full),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .empty_o    (fifo_empty)
    );

    // Output registers always hold the bit on the line this cycle; cnt_q is
    // the number of data bits of the current word still to follow it.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        lsb_d      = lsb_q;
        par_d      = par_q;
        ser_dat_d  = 1'b0;
        ser_vld_d  = 1'b0;
        ser_last_d = 1'b0;
        fifo_pop   = 1'b0;
        start      = 1'b0;
        start_word = word_q;
        next_bit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    word_d   = fifo_head;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                start = 1'b1;
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    next_bit   = lsb_q ? sr_q[0] : sr_q[WIDTH-1];
                    sr_d       = lsb_q ? (sr_q >> 1) : (sr_q << 1);
                    cnt_d      = cnt_q - SER_MOD_W'(1);
                    par_d      = par_q ^ next_bit;
                    ser_vld_d  = 1'b1;
                    ser_dat_d  = next_bit;
                    ser_last_d = (cnt_q == SER_MOD_W'(1)) && !PAR_EN;
                end else if (PAR_EN) begin
                    state_d    = PARITY;
                    ser_vld_d  = 1'b1;
                    ser_dat_d  = par_q;
                    ser_last_d = 1'b1;
                end else if (!fifo_empty) begin
                    // Start straight from the show-ahead head so no gap appears.
                    fifo_pop   = 1'b1;
                    start      = 1'b1;
                    start_word = fifo_head;
                end else begin
                    state_d = IDLE;
                end
            end
            PARITY: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    start      = 1'b1;
                    start_word = fifo_head;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // First bit of a word goes out directly; the rest is parked in sr.
        if (start) begin
            next_bit   = start_word.lsb ? start_word.data[0] : start_word.data[WIDTH-1];
            sr_d       = start_word.lsb ? (start_word.data >> 1) : (start_word.data << 1);
            lsb_d      = start_word.lsb;
            cnt_d      = start_word.mod - SER_MOD_W'(1);
            par_d      = next_bit;
            ser_vld_d  = 1'b1;
            ser_dat_d  = next_bit;
            ser_last_d = (start_word.mod == SER_MOD_W'(1)) && !PAR_EN;
            state_d    = SHIFT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            word_q     <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            lsb_q      <= 1'b0;
            par_q      <= 1'b0;
            ser_dat_q  <= 1'b0;
            ser_vld_q  <= 1'b0;
            ser_last_q <= 1'b0;
            drop_q     <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            lsb_q      <= lsb_d;
            par_q      <= par_d;
            ser_dat_q  <= ser_dat_d;
            ser_vld_q  <= ser_vld_d;
            ser_last_q <= ser_last_d;
            drop_q     <= drop_d;
            init_q     <= 1'b1;
        end
    end

    // init_q keeps ready low throughout reset and raises it on the first edge after release.
    assign data_rdy_o     = init_q & ~fifo_full;
    assign ser_data_o     = ser_dat_q;
    assign ser_data_val_o = ser_vld_q;
    assign ser_last_o     = ser_last_q;
    assign drop_o         = drop_q;
    assign busy_o         = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_serializer_fifo.sv
// Testbench for serializer_fifo: reset, table of single words, latency,
// back-to-back streaming, randomized traffic against a bit-list model, mid-word reset.
module tb_serializer_fifo;

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i = '0;
    logic [4:0]  data_mod_i = '0;
    logic        data_lsb_i = 1'b0;
    logic        data_val_i = 1'b0;
    logic        data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o, drop_o, busy_o;

    serializer_fifo #(.WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_lsb_i     (data_lsb_i),
        .data_val_i     (data_val_i),
        .data_rdy_o     (data_rdy_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .ser_last_o     (ser_last_o),
        .drop_o         (drop_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] cap_q [$];   // observed {last, bit}
    logic [1:0] exp_q [$];   // model {last, bit}
    int drop_cnt = 0, exp_drops = 0;
    int run_len = 0, max_run = 0, zero_viol = 0;
    bit rdy_low_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (ser_data_val_o) begin
            cap_q.push_back({ser_last_o, ser_data_o});
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
            if (ser_data_o || ser_last_o) zero_viol++;
        end
        if (drop_o) drop_cnt++;
        if (!data_rdy_o && rst_n) rdy_low_seen = 1;
    end

    // Reference: the bit list a word should produce, straight from the rules.
    task automatic model_add(input logic [15:0] d, input logic [4:0] m, input logic l);
        logic p, b;
        p = 1'b0;
        if (m == 0 || m > 16) begin
            exp_drops++;
            return;
        end
        for (int i = 0; i < int'(m); i++) begin
            b = l ? d[i] : d[15-i];
            p ^= b;
            exp_q.push_back({(i == int'(m) - 1) && (PAR == 0), b});
        end
        if (PAR != 0) exp_q.push_back({1'b1, p});
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic push_word(input logic [15:0] d, input logic [4:0] m, input logic l);
        int t;
        t = 0;
        data_i = d; data_mod_i = m; data_lsb_i = l; data_val_i = 1'b1;
        while (!data_rdy_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("push_rdy", data_rdy_o, 1);
        if (data_rdy_o) begin
            @(posedge clk);
            model_add(d, m, l);
            @(negedge clk);
        end
        data_val_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk); #1;
        while ((busy_o || ser_data_val_o) && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        check("idle_reached", int'(t < 400), 1);
    endtask

    task automatic compare_model(input string tag);
        int bad;
        bad = 0;
        check({tag, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            if (cap_q[i] != exp_q[i]) begin
                if (bad == 0) $display("  first difference %s at bit %0d: got %b want %b", tag, i, cap_q[i], exp_q[i]);
                bad++;
            end
        end
        check({tag, "_bits"}, bad, 0);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [4:0]  mod;
        logic        lsb;
        logic [15:0] exp_val;   // first-sent bit is bit exp_n-1
        int          exp_n;
        int          exp_drop;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int act, lasts, lastidx, n_exp, t;
        logic [15:0] rd;
        logic [4:0]  rm;

        vecs[0] = '{16'hA5C3, 5'd16, 1'b0, 16'hA5C3, 16, 0};
        vecs[1] = '{16'h00F5, 5'd5,  1'b1, 16'h0015, 5,  0};
        vecs[2] = '{16'h1234, 5'd8,  1'b0, 16'h0012, 8,  0};
        vecs[3] = '{16'hC000, 5'd16, 1'b1, 16'h0003, 16, 0};
        vecs[4] = '{16'h8001, 5'd1,  1'b1, 16'h0001, 1,  0};
        vecs[5] = '{16'h8001, 5'd1,  1'b0, 16'h0001, 1,  0};
        vecs[6] = '{16'h0000, 5'd0,  1'b0, 16'h0000, 0,  1};
        vecs[7] = '{16'hFFFF, 5'd17, 1'b1, 16'h0000, 0,  1};
        vecs[8] = '{16'h00F0, 5'd4,  1'b0, 16'h0000, 4,  0};

        // Reset held for 3 cycles: everything low, ready included.
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o, drop_o, busy_o}, 0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rdy_after_release", data_rdy_o, 1);
        check("busy_after_release", busy_o, 0);

        // First-bit latency: two edges after the accepting edge.
        push_word(16'hFFFF, 5'd2, 1'b0);
        #1;
        t = 0;
        while (!ser_data_val_o && t < 10) begin
            @(posedge clk); @(negedge clk); #1;
            t++;
        end
        check("first_bit_latency", t, 2);
        wait_idle();

        // Table of single words.
        foreach (vecs[i]) begin
            cap_q.delete(); exp_q.delete(); drop_cnt = 0;
            push_word(vecs[i].data, vecs[i].mod, vecs[i].lsb);
            wait_idle();
            n_exp = vecs[i].exp_n + ((vecs[i].exp_n > 0) ? PAR : 0);
            check($sformatf("vec%0d_len", i), cap_q.size(), n_exp);
            if (vecs[i].exp_n > 0 && cap_q.size() > 0) begin
                act = 0; lasts = 0; lastidx = -1;
                for (int k = 0; k < vecs[i].exp_n && k < cap_q.size(); k++) act = (act << 1) | int'(cap_q[k][0]);
                foreach (cap_q[k]) if (cap_q[k][1]) begin lasts++; lastidx = k; end
                check($sformatf("vec%0d_bits", i), act, int'(vecs[i].exp_val));
                check($sformatf("vec%0d_last_cnt", i), lasts, 1);
                check($sformatf("vec%0d_last_pos", i), lastidx, n_exp - 1);
                if (PAR != 0 && cap_q.size() > vecs[i].exp_n)
                    check($sformatf("vec%0d_parity", i), cap_q[vecs[i].exp_n][0], ^vecs[i].exp_val);
            end
            check($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].exp_drop);
        end

        // Back-to-back: six 3-bit words on consecutive cycles.
        cap_q.delete(); exp_q.delete(); max_run = 0; rdy_low_seen = 0;
        for (int i = 0; i < 6; i++) push_word(16'($urandom), 5'd3, 1'($urandom));
        wait_idle();
        check("b2b_contiguous", max_run, 6 * (3 + PAR));
        check("b2b_rdy_dropped", int'(rdy_low_seen), 1);
        compare_model("b2b");

        // Randomized traffic, including invalid mods and idle gaps.
        cap_q.delete(); exp_q.delete(); drop_cnt = 0; exp_drops = 0;
        for (int i = 0; i < 60; i++) begin
            rd = 16'($urandom);
            rm = 5'($urandom_range(0, 19));
            push_word(rd, rm, 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        compare_model("rand");
        check("rand_drops", drop_cnt, exp_drops);

        // Reset in the middle of a word, with a second word still buffered.
        cap_q.delete(); exp_q.delete();
        push_word(16'hA5C3, 5'd16, 1'b0);
        push_word(16'hFFFF, 5'd16, 1'b1);
        t = 0;
        while (cap_q.size() < 7 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        check("mid_bits_before_reset", cap_q.size(), 7);
        check("mid_vld_before_reset", ser_data_val_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_outputs", {data_rdy_o, ser_data_o, ser_data_val_o, ser_last_o, drop_o, busy_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("mid_buffer_lost", busy_o, 0);
        cap_q.delete(); exp_q.delete();
        push_word(16'h3C5A, 5'd16, 1'b1);
        wait_idle();
        compare_model("post_reset");

        check("line_zero_when_invalid", zero_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
